seq_booth_multiplier: RTL

- Parametrised iterative radix-4 Booth multiplier. It is the next generation of the 16x16 signed multiplier.
- Adds generic operand width, a per-operation signed/unsigned mode, a busy indication, and a registered product that holds its value.
- Sits in the datapath as a shared multi-cycle arithmetic unit. It trades latency for area against a single-cycle array multiplier.

---
 rtl/seq_booth_multiplier.sv | 116 +++++++++++
 1 files changed

// File: rtl/seq_booth_multiplier.sv
// Iterative radix-4 Booth multiplier: one Booth digit per cycle, WIDTH/2+1 cycles per product.
// Operands are extended by two bits so signed and unsigned modes share one signed datapath.
module seq_booth_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               input_ready,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               output_valid,
    output logic [2*WIDTH-1:0] prod
);

    localparam int ITER = WIDTH / 2 + 1;
    localparam int EXT  = WIDTH + 2;
    localparam int HW   = EXT + 2;
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(ITER - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t          state;
    logic [CW-1:0]   iter_cnt;
    logic [EXT-1:0]  mcand;
    logic [HW-1:0]   acc_hi;
    logic [EXT-1:0]  acc_lo;
    logic            q_m1;

    logic [2:0]      group;
    logic [HW-1:0]   m_ext;
    logic [HW-1:0]   addend;
    logic [HW-1:0]   sum_hi;
    logic [HW-1:0]   next_hi;
    logic [EXT-1:0]  next_lo;
    logic [EXT-1:0]  a_ext;
    logic [EXT-1:0]  b_ext;

    // Unsigned operands get zero-extended, so the signed datapath sees them as positive.
    assign a_ext = {{2{a[WIDTH-1] & signed_mode}}, a};
    assign b_ext = {{2{b[WIDTH-1] & signed_mode}}, b};

    assign group = {acc_lo[1:0], q_m1};
    assign m_ext = {{2{mcand[EXT-1]}}, mcand};

    always_comb begin
        addend = '0;
        case (group)
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m_ext << 1;
            3'b100:         addend = -(m_ext << 1);
            3'b101, 3'b110: addend = -m_ext;
            default:        addend = '0;
        endcase
    end

    assign sum_hi = acc_hi + addend;

    // Arithmetic shift of the whole {hi, lo} accumulator by one Booth digit.
    assign next_hi = {{2{sum_hi[HW-1]}}, sum_hi[HW-1:2]};
    assign next_lo = {sum_hi[1:0], acc_lo[EXT-1:2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            output_valid <= 1'b0;
            prod         <= '0;
            iter_cnt     <= '0;
            mcand        <= '0;
            acc_hi       <= '0;
            acc_lo       <= '0;
            q_m1         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    output_valid <= 1'b0;
                    if (input_ready) begin
                        mcand    <= a_ext;
                        acc_lo   <= b_ext;
                        acc_hi   <= '0;
                        q_m1     <= 1'b0;
                        iter_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    acc_hi <= next_hi;
                    acc_lo <= next_lo;
                    q_m1   <= acc_lo[1];
                    if (iter_cnt == LAST_ITER) begin
                        // After the last digit the multiplier bits are fully shifted out.
                        prod         <= {next_hi[WIDTH-3:0], next_lo};
                        output_valid <= 1'b1;
                        busy         <= 1'b0;
                        iter_cnt     <= '0;
                        state        <= IDLE;
                    end else begin
                        iter_cnt <= iter_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
